// File: rtl/sprite_plotter.sv
// sprite_plotter: copies one object from ROM to the VGA plot port.
// Handles transparency, solid erase fill and screen-edge clipping.
module sprite_plotter #(
  parameter int LOG_W = 3,
  parameter int LOG_H = 3,
  parameter int SEL_W = 1,
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int TRANSP_EN = 1,
  parameter logic [CW-1:0] TRANSP_COLOUR = '0
) (
  input  logic                         Clock,
  input  logic                         Resetn,
  input  logic                         start,
  input  logic [SEL_W-1:0]             obj_sel,
  input  logic [XW-1:0]                x0,
  input  logic [YW-1:0]                y0,
  input  logic                         erase,
  input  logic [CW-1:0]                erase_colour,
  output logic [SEL_W+LOG_H+LOG_W-1:0] mem_addr,
  input  logic [CW-1:0]                mem_data,
  output logic [XW-1:0]                vga_x,
  output logic [YW-1:0]                vga_y,
  output logic [CW-1:0]                vga_colour,
  output logic                         vga_plot,
  output logic                         busy,
  output logic                         done
);

  localparam logic [XW:0] SW = SCREEN_W[XW:0];
  localparam logic [YW:0] SH = SCREEN_H[YW:0];
  localparam logic TEN = (TRANSP_EN != 0);

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    FLUSH
  } state_t;

  state_t state_q;
  state_t state_d;
  logic load;
  logic step;
  logic last;

  logic [LOG_W-1:0] xc;
  logic [LOG_H-1:0] yc;
  logic [SEL_W-1:0] sel_l;
  logic [XW-1:0]    x0_l;
  logic [YW-1:0]    y0_l;
  logic             erase_l;
  logic [CW-1:0]    ecol_l;

  logic             pv;
  logic             clip_q;
  logic [XW-1:0]    px_q;
  logic [YW-1:0]    py_q;
  logic             done_q;

  logic [XW:0]      xs;
  logic [YW:0]      ys;
  logic             opaque;

  assign last = (&xc) & (&yc);
  assign xs = {1'b0, x0_l} + {{(XW+1-LOG_W){1'b0}}, xc};
  assign ys = {1'b0, y0_l} + {{(YW+1-LOG_H){1'b0}}, yc};

  assign mem_addr = {sel_l, yc, xc};
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign vga_x = px_q;
  assign vga_y = py_q;

  assign opaque = erase_l | ~TEN | (mem_data != TRANSP_COLOUR);
  assign vga_plot = pv & ~clip_q & opaque;
  assign vga_colour = pv ? (erase_l ? ecol_l : mem_data) : '0;

  // Next-state decode: accept start only in IDLE, walk the object in DRAW.
  always_comb begin
    state_d = state_q;
    load = 1'b0;
    step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRAW;
          load = 1'b1;
        end
      end
      DRAW: begin
        step = 1'b1;
        if (last) state_d = FLUSH;
      end
      FLUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters, request latches and the one-stage pixel pipeline.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= IDLE;
      xc <= '0;
      yc <= '0;
      sel_l <= '0;
      x0_l <= '0;
      y0_l <= '0;
      erase_l <= 1'b0;
      ecol_l <= '0;
      pv <= 1'b0;
      clip_q <= 1'b0;
      px_q <= '0;
      py_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        sel_l <= obj_sel;
        x0_l <= x0;
        y0_l <= y0;
        erase_l <= erase;
        ecol_l <= erase_colour;
        xc <= '0;
        yc <= '0;
      end else if (step) begin
        xc <= xc + 1'b1;
        if (&xc) yc <= yc + 1'b1;
      end
      pv <= (state_q == DRAW);
      clip_q <= (xs >= SW) | (ys >= SH);
      px_q <= xs[XW-1:0];
      py_q <= ys[YW-1:0];
      done_q <= (state_q == FLUSH);
    end
  end

endmodule

// File: tb/tb_sprite_plotter.sv
// tb_sprite_plotter: directed checks of sprite_plotter.
// Synchronous ROM model; one task per scenario.
module tb_sprite_plotter;

  logic       Clock;
  logic       Resetn;
  logic       start;
  logic       obj_sel;
  logic [7:0] x0;
  logic [6:0] y0;
  logic       erase;
  logic [2:0] erase_colour;
  logic [6:0] mem_addr;
  logic [2:0] mem_data;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;

  logic [2:0] rom [0:127];

  int checks;
  int errors;

  int px_q[$];
  int py_q[$];
  int pc_q[$];
  int busy_cnt;
  int done_cyc;
  logic done_after;

  sprite_plotter dut (
    .Clock(Clock),
    .Resetn(Resetn),
    .start(start),
    .obj_sel(obj_sel),
    .x0(x0),
    .y0(y0),
    .erase(erase),
    .erase_colour(erase_colour),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .vga_x(vga_x),
    .vga_y(vga_y),
    .vga_colour(vga_colour),
    .vga_plot(vga_plot),
    .busy(busy),
    .done(done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) mem_data <= rom[mem_addr];

  task automatic draw(input logic s, input logic [7:0] x,
                      input logic [6:0] y, input logic er,
                      input logic [2:0] ec, input int pulse_at,
                      input logic [7:0] pulse_x);
    px_q.delete();
    py_q.delete();
    pc_q.delete();
    busy_cnt = 0;
    done_cyc = -1;
    @(negedge Clock);
    obj_sel = s;
    x0 = x;
    y0 = y;
    erase = er;
    erase_colour = ec;
    start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge Clock);
      if (busy) busy_cnt++;
      if (vga_plot) begin
        px_q.push_back(int'(vga_x));
        py_q.push_back(int'(vga_y));
        pc_q.push_back(int'(vga_colour));
      end
      start = (c == pulse_at);
      if (c == pulse_at) x0 = pulse_x;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    start = 1'b0;
    @(negedge Clock);
    done_after = done;
  endtask

  task automatic test_reset;
    Resetn = 1'b0;
    repeat (2) @(negedge Clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || vga_plot !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: busy=%b done=%b plot=%b expected 0 0 0",
               busy, done, vga_plot);
    end
    checks++;
    if (mem_addr !== 7'd0 || vga_x !== 8'd0 || vga_y !== 7'd0 ||
        vga_colour !== 3'd0) begin
      errors++;
      $display("FAIL reset_data: addr=%0d x=%0d y=%0d col=%0d expected 0",
               mem_addr, vga_x, vga_y, vga_colour);
    end
    Resetn = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_basic;
    draw(1'b1, 8'd10, 7'd20, 1'b0, 3'd0, 0, 8'd0);
    checks++;
    if (px_q.size() != 64) begin
      errors++;
      $display("FAIL basic_count: got %0d expected 64", px_q.size());
    end
    checks++;
    if (px_q.size() == 0 || px_q[0] != 10 || py_q[0] != 20 ||
        pc_q[0] != int'(rom[64])) begin
      errors++;
      $display("FAIL basic_first: got (%0d,%0d) c%0d expected (10,20) c%0d",
               px_q.size() ? px_q[0] : -1, py_q.size() ? py_q[0] : -1,
               pc_q.size() ? pc_q[0] : -1, rom[64]);
    end
    checks++;
    if (px_q.size() == 0 || px_q[$] != 17 || py_q[$] != 27 ||
        pc_q[$] != int'(rom[127])) begin
      errors++;
      $display("FAIL basic_last: got (%0d,%0d) c%0d expected (17,27) c%0d",
               px_q.size() ? px_q[$] : -1, py_q.size() ? py_q[$] : -1,
               pc_q.size() ? pc_q[$] : -1, rom[127]);
    end
    checks++;
    if (busy_cnt != 65) begin
      errors++;
      $display("FAIL basic_busy: got %0d cycles expected 65", busy_cnt);
    end
    checks++;
    if (done_cyc != 66) begin
      errors++;
      $display("FAIL basic_done_time: got %0d expected 66", done_cyc);
    end
    checks++;
    if (done_after !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_width: got %b expected 0", done_after);
    end
  endtask

  task automatic test_transparency;
    int bad;
    for (int i = 0; i < 64; i++)
      rom[i] = (i % 2 == 0) ? 3'd0 : 3'(i % 7 + 1);
    draw(1'b0, 8'd40, 7'd30, 1'b0, 3'd0, 0, 8'd0);
    bad = 0;
    foreach (px_q[i]) if (((px_q[i] - 40) % 2) != 1) bad++;
    checks++;
    if (px_q.size() != 32) begin
      errors++;
      $display("FAIL transp_count: got %0d expected 32", px_q.size());
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL transp_columns: got %0d even-column plots expected 0",
               bad);
    end
    checks++;
    if (px_q.size() == 0 || px_q[0] != 41 || py_q[0] != 30 ||
        pc_q[0] != int'(rom[1])) begin
      errors++;
      $display("FAIL transp_first: got (%0d,%0d) c%0d expected (41,30) c%0d",
               px_q.size() ? px_q[0] : -1, py_q.size() ? py_q[0] : -1,
               pc_q.size() ? pc_q[0] : -1, rom[1]);
    end
  endtask

  task automatic test_clipping;
    int bad;
    draw(1'b1, 8'd156, 7'd116, 1'b0, 3'd0, 0, 8'd0);
    bad = 0;
    foreach (px_q[i])
      if (px_q[i] < 156 || px_q[i] > 159 || py_q[i] < 116 || py_q[i] > 119)
        bad++;
    checks++;
    if (px_q.size() != 16) begin
      errors++;
      $display("FAIL clip_count: got %0d expected 16", px_q.size());
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clip_range: got %0d out-of-window plots expected 0", bad);
    end
    checks++;
    if (done_cyc != 66) begin
      errors++;
      $display("FAIL clip_done_time: got %0d expected 66", done_cyc);
    end
    draw(1'b1, 8'd252, 7'd0, 1'b0, 3'd0, 0, 8'd0);
    checks++;
    if (px_q.size() != 0) begin
      errors++;
      $display("FAIL clip_nowrap: got %0d plots expected 0", px_q.size());
    end
  endtask

  task automatic test_erase;
    logic [63:0] cov;
    int bad;
    for (int i = 0; i < 64; i++) rom[i] = 3'd0;
    draw(1'b0, 8'd0, 7'd0, 1'b1, 3'd7, 0, 8'd0);
    cov = '0;
    bad = 0;
    foreach (px_q[i]) begin
      if (pc_q[i] != 7 || px_q[i] > 7 || py_q[i] > 7) bad++;
      else cov[py_q[i] * 8 + px_q[i]] = 1'b1;
    end
    checks++;
    if (px_q.size() != 64) begin
      errors++;
      $display("FAIL erase_count: got %0d expected 64", px_q.size());
    end
    checks++;
    if (bad != 0 || cov !== {64{1'b1}}) begin
      errors++;
      $display("FAIL erase_fill: got bad=%0d cov=%h expected 0 ffffffffffffffff",
               bad, cov);
    end
  endtask

  task automatic test_ignore_start;
    int bad;
    draw(1'b1, 8'd10, 7'd20, 1'b0, 3'd0, 10, 8'd100);
    bad = 0;
    foreach (px_q[i]) if (px_q[i] < 10 || px_q[i] > 17) bad++;
    checks++;
    if (px_q.size() != 64 || bad != 0) begin
      errors++;
      $display("FAIL ignore_start: got %0d plots %0d off-x expected 64 0",
               px_q.size(), bad);
    end
    checks++;
    if (done_cyc != 66) begin
      errors++;
      $display("FAIL ignore_done_time: got %0d expected 66", done_cyc);
    end
  endtask

  task automatic test_back_to_back;
    int d1;
    int d2;
    int n2;
    d1 = -1;
    d2 = -1;
    n2 = 0;
    @(negedge Clock);
    obj_sel = 1'b1;
    x0 = 8'd20;
    y0 = 7'd40;
    erase = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge Clock);
      if (d1 > 0 && vga_plot) n2++;
      if (d1 > 0 && c == d1 + 1) begin
        checks++;
        if (busy !== 1'b1 || mem_addr !== 7'd64) begin
          errors++;
          $display("FAIL b2b_restart: got busy=%b addr=%0d expected 1 64",
                   busy, mem_addr);
        end
        start = 1'b0;
      end
      if (done) begin
        if (d1 < 0) d1 = c;
        else begin
          d2 = c;
          break;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (d1 != 66 || d2 != 132) begin
      errors++;
      $display("FAIL b2b_done_times: got %0d %0d expected 66 132", d1, d2);
    end
    checks++;
    if (n2 != 64) begin
      errors++;
      $display("FAIL b2b_second_count: got %0d expected 64", n2);
    end
  endtask

  task automatic test_reset_mid;
    int nd;
    int np;
    @(negedge Clock);
    obj_sel = 1'b1;
    x0 = 8'd10;
    y0 = 7'd20;
    erase = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      @(negedge Clock);
      start = 1'b0;
    end
    Resetn = 1'b0;
    @(negedge Clock);
    checks++;
    if (busy !== 1'b0 || vga_plot !== 1'b0 || mem_addr !== 7'd0 ||
        done !== 1'b0) begin
      errors++;
      $display("FAIL midreset: got busy=%b plot=%b addr=%0d done=%b expected 0",
               busy, vga_plot, mem_addr, done);
    end
    Resetn = 1'b1;
    nd = 0;
    np = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge Clock);
      if (done) nd++;
      if (vga_plot) np++;
    end
    checks++;
    if (nd != 0 || np != 0) begin
      errors++;
      $display("FAIL midreset_quiet: got %0d done %0d plots expected 0 0",
               nd, np);
    end
    draw(1'b1, 8'd10, 7'd20, 1'b0, 3'd0, 0, 8'd0);
    checks++;
    if (px_q.size() != 64 || done_cyc != 66) begin
      errors++;
      $display("FAIL midreset_fresh: got %0d plots done@%0d expected 64 66",
               px_q.size(), done_cyc);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    start = 1'b0;
    obj_sel = 1'b0;
    x0 = '0;
    y0 = '0;
    erase = 1'b0;
    erase_colour = '0;
    for (int i = 0; i < 128; i++) rom[i] = 3'(i % 7 + 1);
    test_reset;
    test_basic;
    test_transparency;
    test_clipping;
    test_erase;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_plotter.md
Name: sprite_plotter

Overview:
- Parametrised sprite-drawing engine that copies a 2^LOG_W x 2^LOG_H object from a bank of NUM_OBJ = 2^SEL_W objects in external ROM onto the VGA adapter plot port at a latched (x0,y0).
- Adds a start/busy/done handshake, transparent-colour skipping, an erase (solid fill) mode, and screen-edge clipping.
- Sits between game control logic (board and piece drawing) and vga_adapter, replacing the free-running column/row counter scheme.

Parameters:
LOG_W, 3, log2 of object width in pixels (OBJ_W = 2^LOG_W)
LOG_H, 3, log2 of object height in pixels (OBJ_H = 2^LOG_H)
SEL_W, 1, object-select width; NUM_OBJ = 2^SEL_W objects in ROM
XW, 8, x coordinate width
YW, 7, y coordinate width
CW, 3, colour width
SCREEN_W, 160, visible columns; pixels with x >= SCREEN_W are clipped
SCREEN_H, 120, visible rows; pixels with y >= SCREEN_H are clipped
TRANSP_EN, 1, 1 = ROM pixels equal to TRANSP_COLOUR are not plotted
TRANSP_COLOUR, 3'b000, transparent colour value

Ports:
Clock  in  1  system clock
Resetn  in  1  synchronous, active-low reset
start  in  1  request a draw; sampled only in IDLE
obj_sel  in  SEL_W  object index; latched on accepted start
x0  in  XW  top-left x; latched on accepted start
y0  in  YW  top-left y; latched on accepted start
erase  in  1  1 = fill the object rectangle with erase_colour; latched on accepted start
erase_colour  in  CW  fill colour for erase mode; latched on accepted start
mem_addr  out  SEL_W+LOG_H+LOG_W  ROM address {sel, yc, xc}
mem_data  in  CW  ROM data, valid 1 cycle after mem_addr (synchronous ROM)
vga_x  out  XW  plot x
vga_y  out  YW  plot y
vga_colour  out  CW  plot colour
vga_plot  out  1  plot strobe for vga_adapter
busy  out  1  high while a draw is in progress
done  out  1  single-cycle pulse when a draw completes

Behaviour:
- Reset (Resetn=0 at posedge): state=IDLE; xc, yc, all latches = 0; vga_x=vga_y=vga_colour=0; vga_plot=0; busy=0; done=0; mem_addr=0. Reset wins over every other input, including mid-draw; an aborted draw produces no done pulse.
- States: IDLE, DRAW, FLUSH.
- IDLE: busy=0. If start=1 at a posedge, latch obj_sel, x0, y0, erase and erase_colour; clear xc and yc; go to DRAW.
- DRAW: busy=1.
  - mem_addr = {sel_l, yc, xc}, driven combinationally from the registered counters.
  - xc increments every cycle. At xc = OBJ_W-1, xc wraps to 0 and yc increments.
  - At xc = OBJ_W-1 and yc = OBJ_H-1, go to FLUSH. DRAW lasts exactly OBJ_W*OBJ_H cycles.
- Pixel pipeline: the address/coordinate issued in cycle k appears on the vga_* outputs in cycle k+1. A one-stage valid/x/y register stays aligned with ROM latency.
  - vga_x = (x0_l + xc) truncated to XW.
  - vga_y = (y0_l + yc) truncated to YW.
  - Clipping: the sum is computed at XW+1 / YW+1 bits. If it is >= SCREEN_W or >= SCREEN_H, the pixel is suppressed (no wrap-around onto the left or top edge).
- vga_colour = erase_l ? erase_colour_l : mem_data.
- vga_plot = pipeline_valid & ~clipped & (erase_l | ~TRANSP_EN | mem_data != TRANSP_COLOUR). In erase mode, transparency is ignored.
- FLUSH: busy=1; the last pixel is presented on the vga_* outputs; go to IDLE with done=1 for exactly one cycle (busy=0 in that cycle).
- start while busy is ignored; it is not queued. start in the same cycle as done is accepted, giving back-to-back draws with no gap beyond that cycle.
- Timing: start sampled at edge E0.
  - busy high for OBJ_W*OBJ_H+1 cycles.
  - vga_plot eligible in cycles after E1 .. E(OBJ_W*OBJ_H).
  - done high in the cycle after E(OBJ_W*OBJ_H+1).
- Inputs x0, y0, obj_sel, erase and erase_colour may change during a draw without effect.

Test Plan:
1. Reset, then start with obj_sel=1, x0=10, y0=20, erase=0, and a ROM holding no colour 0 -> 64 plot strobes. First (10,20) colour=ROM[64]; last (17,27) colour=ROM[127]. busy high 65 cycles; done one cycle 66 cycles after E0.
2. Transparency: object 0 ROM with colour 3'b000 at all even xc -> exactly 32 plots, only at odd columns (x0+1, x0+3, ...).
3. Clipping: x0=156, y0=116 -> only xc 0..3 and yc 0..3 are plotted (16 strobes). No strobe with x<156 or y<116; done timing unchanged.
4. Erase: erase=1, erase_colour=3'b111, x0=0, y0=0, ROM full of 3'b000 -> 64 plots, all colour 3'b111, covering (0..7, 0..7).
5. Start pulsed again mid-draw, with x0 changed -> ignored; the original coordinates complete. Start held high through done -> a second draw begins the cycle after done.
6. Resetn=0 for one cycle at pixel 30 -> next cycle: busy=0, vga_plot=0, mem_addr=0, no done pulse. A fresh start then completes normally.
